// File: rtl/sd_model_load_ctrl.sv
// SD model loader: reads SECTOR_NUM consecutive sectors through the SPI
// sector-read engine, packs the byte stream into 32-bit words and writes
// them to model memory through a small word FIFO. Retries failed sectors
// and reports sticky done/error status to the CPU side.
module sd_model_load_ctrl #(
  parameter logic [31:0] SECTOR_START = 32'd8192,
  parameter logic [15:0] SECTOR_NUM   = 16'd64,
  parameter logic [23:0] TIMEOUT_CYC  = 24'd5000000,
  parameter logic [1:0]  MAX_RETRY    = 2'd3,
  parameter int          MEM_AW       = 16
) (
  input  logic              clk_ref,
  input  logic              arst_n,
  input  logic              start,
  input  logic              sd_init_done,
  output logic              rd_start,
  output logic [31:0]       rd_sec_addr,
  input  logic              rd_busy,
  input  logic              rd_val_en,
  input  logic [7:0]        rd_val_data,
  output logic              mem_wr_en,
  output logic [MEM_AW-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  input  logic              mem_wr_ready,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_WAIT_INIT = 4'd1;
  localparam logic [3:0] ST_ISSUE     = 4'd2;
  localparam logic [3:0] ST_WAIT_BUSY = 4'd3;
  localparam logic [3:0] ST_RECV      = 4'd4;
  localparam logic [3:0] ST_DRAIN     = 4'd5;
  localparam logic [3:0] ST_NEXT      = 4'd6;
  localparam logic [3:0] ST_RETRY     = 4'd7;
  localparam logic [3:0] ST_DONE      = 4'd8;
  localparam logic [3:0] ST_ERR       = 4'd9;

  localparam logic [9:0] SECTOR_BYTES = 10'd512;

  logic [3:0]  state;
  logic [15:0] sec_idx;
  logic [1:0]  retry_cnt;
  logic [9:0]  byte_cnt;
  logic [23:0] timeout_cnt;
  logic [23:0] pack_buf;

  // Word FIFO between the byte packer and the memory write port.
  logic [31:0]       fifo_data [4];
  logic [MEM_AW-1:0] fifo_addr [4];
  logic [1:0]        fifo_wp;
  logic [1:0]        fifo_rp;
  logic [2:0]        fifo_cnt;

  logic              in_read;
  logic              byte_accept;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_ovf;
  logic              sector_ok;
  logic              timed_out;
  logic              short_end;
  logic              read_fail;
  logic              go_err;
  logic [6:0]        word_idx;
  logic [MEM_AW-1:0] push_addr;
  logic [31:0]       push_data;

  // Byte intake: only while a read is in flight, and never past 512 bytes.
  assign in_read     = (state == ST_WAIT_BUSY) || (state == ST_RECV);
  assign byte_accept = in_read && rd_val_en && (byte_cnt != SECTOR_BYTES);
  assign fifo_push   = byte_accept && (byte_cnt[1:0] == 2'd3);
  assign word_idx    = byte_cnt[8:2];
  assign push_addr   = MEM_AW'({sec_idx, word_idx});
  assign push_data   = {rd_val_data, pack_buf};

  assign fifo_empty  = (fifo_cnt == 3'd0);
  assign fifo_full   = (fifo_cnt == 3'd4);
  assign fifo_pop    = !fifo_empty && mem_wr_ready;
  assign fifo_ovf    = fifo_push && fifo_full && !fifo_pop;

  // A complete sector wins over a coincident timeout.
  assign sector_ok   = (state == ST_RECV) && !rd_busy && (byte_cnt == SECTOR_BYTES);
  assign timed_out   = in_read && (timeout_cnt == TIMEOUT_CYC);
  assign short_end   = (state == ST_RECV) && !rd_busy && (byte_cnt != SECTOR_BYTES);
  assign read_fail   = (timed_out || short_end) && !sector_ok;
  assign go_err      = fifo_ovf || (read_fail && (retry_cnt == MAX_RETRY));

  assign rd_start    = (state == ST_ISSUE);
  assign busy        = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERR);
  assign mem_wr_en   = !fifo_empty;
  assign mem_wr_addr = mem_wr_en ? fifo_addr[fifo_rp] : '0;
  assign mem_wr_data = mem_wr_en ? fifo_data[fifo_rp] : '0;

  // Load sequencer: state, sector/retry bookkeeping, byte packing, timeout.
  always_ff @(posedge clk_ref or negedge arst_n) begin
    if (!arst_n) begin
      state       <= ST_IDLE;
      sec_idx     <= '0;
      retry_cnt   <= '0;
      byte_cnt    <= '0;
      timeout_cnt <= '0;
      pack_buf    <= '0;
      rd_sec_addr <= '0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // sees the pre-edge values and later assignments override earlier ones.
      if ((state == ST_ISSUE) || rd_val_en) begin
        timeout_cnt <= '0;
      end else if (in_read) begin
        timeout_cnt <= timeout_cnt + 24'd1;
      end

      if (byte_accept) begin
        byte_cnt <= byte_cnt + 10'd1;
        case (byte_cnt[1:0])
          2'd0:    pack_buf[7:0]   <= rd_val_data;
          2'd1:    pack_buf[15:8]  <= rd_val_data;
          2'd2:    pack_buf[23:16] <= rd_val_data;
          default: ;
        endcase
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            sec_idx   <= '0;
            retry_cnt <= '0;
            state     <= ST_WAIT_INIT;
          end
        end
        ST_WAIT_INIT: begin
          if (sd_init_done) begin
            rd_sec_addr <= SECTOR_START + {16'd0, sec_idx};
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          byte_cnt <= '0;
          state    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY, ST_RECV: begin
          if (sector_ok) begin
            state <= ST_DRAIN;
          end else if (read_fail) begin
            // Exhausted retries are handled by the error override below.
            if (retry_cnt != MAX_RETRY) begin
              retry_cnt <= retry_cnt + 2'd1;
              byte_cnt  <= '0;
              state     <= ST_RETRY;
            end
          end else if ((state == ST_WAIT_BUSY) && rd_busy) begin
            state <= ST_RECV;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (sec_idx == SECTOR_NUM - 16'd1) begin
            load_done <= 1'b1;
            state     <= ST_DONE;
          end else begin
            sec_idx     <= sec_idx + 16'd1;
            retry_cnt   <= '0;
            rd_sec_addr <= SECTOR_START + {16'd0, sec_idx + 16'd1};
            state       <= ST_ISSUE;
          end
        end
        ST_RETRY: begin
          // Words already queued for this sector drain before re-reading it.
          if (fifo_empty) state <= ST_ISSUE;
        end
        ST_DONE, ST_ERR: begin
          if (start) begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            sec_idx   <= '0;
            retry_cnt <= '0;
            state     <= ST_WAIT_INIT;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (go_err) begin
        load_err <= 1'b1;
        state    <= ST_ERR;
      end
    end
  end

  // FIFO pointers and occupancy; flushed when the load enters ERR.
  always_ff @(posedge clk_ref or negedge arst_n) begin
    if (!arst_n) begin
      fifo_wp  <= '0;
      fifo_rp  <= '0;
      fifo_cnt <= '0;
    end else if (go_err) begin
      fifo_wp  <= '0;
      fifo_rp  <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) fifo_wp <= fifo_wp + 2'd1;
      if (fifo_pop)  fifo_rp <= fifo_rp + 2'd1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: ;
      endcase
    end
  end

  // FIFO storage write.
  // NOTE: the storage array has no reset; fifo_cnt says which entries are
  // live and the memory outputs are forced to zero while the FIFO is empty.
  always_ff @(posedge clk_ref) begin
    if (fifo_push) begin
      fifo_data[fifo_wp] <= push_data;
      fifo_addr[fifo_wp] <= push_addr;
    end
  end

endmodule

// File: tb/tb_sd_model_load_ctrl.sv
// Self-checking bench for sd_model_load_ctrl: a behavioural sector-read
// engine drives bytes and queues the expected memory writes, a monitor
// pops and compares every accepted write, and scenario tasks check status.
module tb_sd_model_load_ctrl;

  localparam int          MEM_AW = 16;
  localparam logic [31:0] SEC0   = 32'd8192;

  typedef struct packed {
    logic [MEM_AW-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk_ref = 1'b0;
  logic              arst_n;
  logic              start;
  logic              sd_init_done;
  logic              rd_start;
  logic [31:0]       rd_sec_addr;
  logic              rd_busy;
  logic              rd_val_en;
  logic [7:0]        rd_val_data;
  logic              mem_wr_en;
  logic [MEM_AW-1:0] mem_wr_addr;
  logic [31:0]       mem_wr_data;
  logic              mem_wr_ready;
  logic              busy;
  logic              load_done;
  logic              load_err;

  int checks = 0;
  int errors = 0;

  wr_t sb_q[$];
  wr_t mon_exp;

  // Engine behaviour knobs.
  int byte_gap   = 1;
  int silent_sec = -1;
  int short_sec  = -1;
  int short_left = 0;
  bit eng_active = 1'b0;

  // Per-scenario observations.
  int          wr_count;
  int          wr_hi_count;
  int          rds_count;
  int          rds_not_first;
  logic [31:0] first_rd_addr;
  logic [31:0] wr_seen [int];

  sd_model_load_ctrl #(
    .SECTOR_START(SEC0),
    .SECTOR_NUM  (16'd2),
    .TIMEOUT_CYC (24'd100),
    .MAX_RETRY   (2'd3),
    .MEM_AW      (MEM_AW)
  ) dut (
    .clk_ref     (clk_ref),
    .arst_n      (arst_n),
    .start       (start),
    .sd_init_done(sd_init_done),
    .rd_start    (rd_start),
    .rd_sec_addr (rd_sec_addr),
    .rd_busy     (rd_busy),
    .rd_val_en   (rd_val_en),
    .rd_val_data (rd_val_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_ready(mem_wr_ready),
    .busy        (busy),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  always #5 clk_ref = ~clk_ref;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_ref);
    #1;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_stats();
    wr_count      = 0;
    wr_hi_count   = 0;
    rds_count     = 0;
    rds_not_first = 0;
    first_rd_addr = '0;
    wr_seen.delete();
  endtask

  function automatic logic [31:0] seen(input int a);
    if (wr_seen.exists(a)) return wr_seen[a];
    return 32'hxxxx_xxxx;
  endfunction

  // Wait for load_done or load_err, bounded by a cycle budget.
  task automatic wait_end(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_ref);
      if (load_done === 1'b1 || load_err === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rd_busy(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_ref);
      if (rd_busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_engine_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_ref);
      if (!eng_active) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Behavioural sector-read engine: bytes 00..FF repeating per sector.
  task automatic engine_read(input logic [31:0] sec_addr);
    int          n;
    int          idx;
    logic [31:0] word;
    wr_t         e;
    idx = int'(sec_addr - SEC0);
    if (idx == silent_sec) return;
    n = 512;
    if (idx == short_sec && short_left > 0) begin
      n = 300;
      short_left--;
    end
    eng_active = 1'b1;
    word = '0;
    repeat (2) @(posedge clk_ref);
    #1;
    rd_busy = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (arst_n !== 1'b1 || busy !== 1'b1) break;
      rd_val_en   = 1'b1;
      rd_val_data = 8'(i);
      word = {rd_val_data, word[31:8]};
      if (i % 4 == 3) begin
        e.addr = MEM_AW'(idx * 128 + i / 4);
        e.data = word;
        sb_q.push_back(e);
      end
      if (byte_gap > 1) begin
        tick();
        rd_val_en = 1'b0;
        repeat (byte_gap - 2) @(posedge clk_ref);
      end
    end
    tick();
    rd_val_en  = 1'b0;
    rd_busy    = 1'b0;
    eng_active = 1'b0;
  endtask

  initial begin
    rd_busy     = 1'b0;
    rd_val_en   = 1'b0;
    rd_val_data = '0;
    forever begin
      @(negedge clk_ref);
      if (arst_n === 1'b1 && rd_start === 1'b1) engine_read(rd_sec_addr);
    end
  end

  // Monitor: counts read requests and scoreboards every accepted write.
  initial begin
    forever begin
      @(negedge clk_ref);
      if (arst_n === 1'b1) begin
        if (rd_start === 1'b1) begin
          if (rds_count == 0) first_rd_addr = rd_sec_addr;
          rds_count++;
          if (rd_sec_addr !== SEC0) rds_not_first++;
        end
        if (mem_wr_en === 1'b1 && mem_wr_ready === 1'b1) begin
          wr_count++;
          if (mem_wr_addr >= MEM_AW'(128)) wr_hi_count++;
          wr_seen[int'(mem_wr_addr)] = mem_wr_data;
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected: got addr %0d data %h, expected no write",
                     mem_wr_addr, mem_wr_data);
          end else begin
            mon_exp = sb_q.pop_front();
            if (mem_wr_addr !== mon_exp.addr || mem_wr_data !== mon_exp.data) begin
              errors++;
              $display("FAIL write_data: got addr %0d data %h, expected addr %0d data %h",
                       mem_wr_addr, mem_wr_data, mon_exp.addr, mon_exp.data);
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    arst_n       = 1'b0;
    start        = 1'b0;
    sd_init_done = 1'b0;
    mem_wr_ready = 1'b1;
    clear_stats();
    repeat (3) @(negedge clk_ref);
    checks++;
    if ({rd_start, mem_wr_en, busy, load_done, load_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 00000",
               {rd_start, mem_wr_en, busy, load_done, load_err});
    end
    checks++;
    if (rd_sec_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_sec_addr: got %h, expected 0", rd_sec_addr);
    end
    checks++;
    if ({mem_wr_addr, mem_wr_data} !== '0) begin
      errors++;
      $display("FAIL reset_mem_bus: got addr %h data %h, expected 0", mem_wr_addr, mem_wr_data);
    end
    tick();
    arst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic_load();
    bit ok;
    clear_stats();
    sd_init_done = 1'b1;
    byte_gap     = 1;
    pulse_start();
    wait_end(5000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: got no completion, expected done"); end
    checks++;
    if ({load_done, load_err, busy} !== 3'b100) begin
      errors++;
      $display("FAIL basic_status: got done/err/busy %b, expected 100", {load_done, load_err, busy});
    end
    checks++;
    if (wr_count != 256) begin errors++; $display("FAIL basic_wr_count: got %0d, expected 256", wr_count); end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL basic_pending: got %0d, expected 0", sb_q.size()); end
    checks++;
    if (seen(0) !== 32'h03020100) begin errors++; $display("FAIL basic_addr0: got %h, expected 03020100", seen(0)); end
    checks++;
    if (seen(128) !== 32'h03020100) begin errors++; $display("FAIL basic_addr128: got %h, expected 03020100", seen(128)); end
    checks++;
    if (seen(255) !== 32'hFFFEFDFC) begin errors++; $display("FAIL basic_addr255: got %h, expected fffefdfc", seen(255)); end
  endtask

  task automatic test_init_wait();
    bit          ok;
    bit          found;
    logic [31:0] addr;
    clear_stats();
    sd_init_done = 1'b0;
    pulse_start();
    repeat (1000) @(posedge clk_ref);
    #1;
    checks++;
    if (rds_count != 0) begin errors++; $display("FAIL init_no_read: got %0d rd_start, expected 0", rds_count); end
    checks++;
    if ({busy, load_done} !== 2'b10) begin
      errors++;
      $display("FAIL init_status: got busy/done %b, expected 10", {busy, load_done});
    end
    sd_init_done = 1'b1;
    found = 1'b0;
    addr  = '0;
    for (int i = 0; i < 2 && !found; i++) begin
      @(negedge clk_ref);
      if (rd_start === 1'b1) begin
        found = 1'b1;
        addr  = rd_sec_addr;
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL init_rd_start: got none within 2 cycles, expected pulse"); end
    checks++;
    if (addr !== SEC0) begin errors++; $display("FAIL init_sec_addr: got %0d, expected 8192", addr); end
    wait_end(5000, ok);
    checks++;
    if (!ok || load_done !== 1'b1 || wr_count != 256) begin
      errors++;
      $display("FAIL init_complete: got done %b writes %0d, expected 1 and 256", load_done, wr_count);
    end
  endtask

  task automatic test_timeout_err();
    bit ok;
    clear_stats();
    silent_sec = 0;
    pulse_start();
    wait_end(3000, ok);
    repeat (20) @(negedge clk_ref);
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_wait: got no completion, expected err"); end
    checks++;
    if (rds_count != 4 || rds_not_first != 0) begin
      errors++;
      $display("FAIL timeout_retries: got %0d rd_start (%0d other sector), expected 4 (0)",
               rds_count, rds_not_first);
    end
    checks++;
    if ({load_err, load_done, busy, mem_wr_en} !== 4'b1000) begin
      errors++;
      $display("FAIL timeout_status: got err/done/busy/wr_en %b, expected 1000",
               {load_err, load_done, busy, mem_wr_en});
    end
    checks++;
    if (wr_count != 0) begin errors++; $display("FAIL timeout_writes: got %0d, expected 0", wr_count); end
    silent_sec = -1;
  endtask

  task automatic test_short_retry();
    bit ok;
    clear_stats();
    short_sec  = 1;
    short_left = 1;
    pulse_start();
    wait_end(5000, ok);
    checks++;
    if (!ok || {load_done, load_err} !== 2'b10) begin
      errors++;
      $display("FAIL short_status: got done/err %b, expected 10", {load_done, load_err});
    end
    checks++;
    if (rds_count != 3) begin errors++; $display("FAIL short_reads: got %0d, expected 3", rds_count); end
    checks++;
    if (wr_count != 331 || wr_hi_count != 203) begin
      errors++;
      $display("FAIL short_writes: got %0d total %0d high, expected 331 and 203", wr_count, wr_hi_count);
    end
    checks++;
    if (seen(128) !== 32'h03020100 || seen(255) !== 32'hFFFEFDFC) begin
      errors++;
      $display("FAIL short_rewrite: got %h %h, expected 03020100 fffefdfc", seen(128), seen(255));
    end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL short_pending: got %0d, expected 0", sb_q.size()); end
    short_sec = -1;
  endtask

  task automatic test_backpressure();
    bit ok;
    bit idle_ok;
    clear_stats();
    byte_gap = 8;
    pulse_start();
    wait_rd_busy(50, ok);
    tick();
    repeat (60) tick();
    mem_wr_ready = 1'b0;
    repeat (20) tick();
    mem_wr_ready = 1'b1;
    wait_end(20000, ok);
    checks++;
    if (!ok || {load_done, load_err} !== 2'b10) begin
      errors++;
      $display("FAIL bp_short_status: got done/err %b, expected 10", {load_done, load_err});
    end
    checks++;
    if (wr_count != 256 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL bp_short_writes: got %0d writes %0d pending, expected 256 and 0", wr_count, sb_q.size());
    end

    clear_stats();
    pulse_start();
    wait_rd_busy(50, ok);
    tick();
    repeat (60) tick();
    mem_wr_ready = 1'b0;
    repeat (200) tick();
    @(negedge clk_ref);
    checks++;
    if ({load_err, load_done, busy, mem_wr_en} !== 4'b1000) begin
      errors++;
      $display("FAIL bp_overflow: got err/done/busy/wr_en %b, expected 1000",
               {load_err, load_done, busy, mem_wr_en});
    end
    tick();
    mem_wr_ready = 1'b1;
    wait_engine_idle(100, idle_ok);
    checks++;
    if (!idle_ok) begin errors++; $display("FAIL bp_engine_idle: got engine still active, expected idle"); end
    sb_q.delete();
    byte_gap = 1;
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    clear_stats();
    pulse_start();
    wait_rd_busy(50, ok);
    tick();
    repeat (100) tick();
    arst_n = 1'b0;
    @(negedge clk_ref);
    checks++;
    if ({rd_start, mem_wr_en, busy, load_done, load_err} !== 5'b0 ||
        rd_sec_addr !== 32'd0 || {mem_wr_addr, mem_wr_data} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got flags %b sec %h addr %h data %h, expected all 0",
               {rd_start, mem_wr_en, busy, load_done, load_err}, rd_sec_addr, mem_wr_addr, mem_wr_data);
    end
    repeat (3) tick();
    arst_n = 1'b1;
    wait_engine_idle(50, ok);
    sb_q.delete();
    repeat (5) tick();
    clear_stats();
    pulse_start();
    wait_end(5000, ok);
    checks++;
    if (first_rd_addr !== SEC0) begin
      errors++;
      $display("FAIL midreset_restart_addr: got %0d, expected 8192", first_rd_addr);
    end
    checks++;
    if (!ok || {load_done, load_err} !== 2'b10 || wr_count != 256 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_reload: got done/err %b writes %0d pending %0d, expected 10 256 0",
               {load_done, load_err}, wr_count, sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_init_wait();
    test_timeout_err();
    test_short_retry();
    test_backpressure();
    test_reset_mid_load();
    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
